// File: rtl/fetch_stage.sv
// Stage I fetch front end: owns the PC, issues synchronous I-cache reads and
// presents inst/pc to decode, handling redirects, stalls and kill bubbles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] alu_target,
  input  logic        inst_kill,
  output logic [31:0] icache_addr,
  output logic        icache_re,
  input  logic [31:0] icache_dout,
  output logic [31:0] inst_I,
  output logic [31:0] pc_I,
  output logic        inst_valid_I,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] slot_inst;
  logic [31:0] next_addr;

  // In HOLD the cache output no longer belongs to the presented slot.
  assign slot_inst = (state_q == HOLD) ? hold_inst_q : icache_dout;
  assign next_addr = (pc_sel == 2'b01) ? {alu_target[31:2], 2'b00}
                                       : fetch_pc_q + 32'd4;

  assign icache_re   = reset;
  assign fetch_count = fetch_count_q;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    hold_inst_d   = hold_inst_q;
    fetch_count_d = fetch_count_q;
    icache_addr   = fetch_pc_q;
    inst_I        = NOP_INST;
    inst_valid_I  = 1'b0;
    pc_I          = fetch_pc_q;

    case (state_q)
      BOOT: begin
        icache_addr = RESET_PC;
        pc_I        = RESET_PC;
        if (!stall) begin
          fetch_pc_d = RESET_PC;
          state_d    = RUN;
        end
      end
      RUN, HOLD: begin
        inst_I       = inst_kill ? NOP_INST : slot_inst;
        inst_valid_I = ~inst_kill;
        if (stall) begin
          // Re-issue the current address so the cache keeps returning it.
          icache_addr = fetch_pc_q;
          if (state_q == RUN) begin
            hold_inst_d = icache_dout;
            state_d     = HOLD;
          end
        end else begin
          icache_addr   = next_addr;
          fetch_pc_d    = next_addr;
          fetch_count_d = fetch_count_q + {31'd0, inst_valid_I};
          state_d       = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      hold_inst_q   <= NOP_INST;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      hold_inst_q   <= hold_inst_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule
